// File: rtl/fb_fetch_pkg.sv
`default_nettype none
// ============================================================================
// Module   : fb_fetch_pkg
// Purpose  : Shared types and constants for the frame-buffer line fetcher.
//            Holds the fetch FSM state encoding, the SDRAM host-port widths
//            and the saturation limit of the underrun counter.
// Revision : 1.0 - initial release
// ============================================================================
package fb_fetch_pkg;

  localparam int SDR_AW = 22;
  localparam int SDR_DW = 16;

  localparam logic [15:0] UNDERRUN_MAX = 16'hFFFF;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_DRAIN = 2'd2,
    ST_FLUSH = 2'd3
  } fb_state_t;

endpackage
`default_nettype wire

// File: rtl/sync_fifo.sv
`default_nettype none
// ============================================================================
// Module   : sync_fifo
// Purpose  : Single-clock FIFO holding one scan line of pixel words.
//            rd_data always shows the head entry (show-ahead); the consumer
//            registers it when it pops.
// Ports    : clk, rst (sync, active-high)
//            wr_en / wr_data  - push (ignored when full)
//            rd_en            - pop (ignored when empty)
//            rd_data          - head entry
//            empty / full     - occupancy flags
// Revision : 1.0 - initial release
// ============================================================================
module sync_fifo #(
  parameter int DATA_WIDTH = 16,
  parameter int RAM_DEPTH  = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  empty,
  output logic                  full
);

  localparam int AW = $clog2(RAM_DEPTH);

  logic [DATA_WIDTH-1:0] mem [RAM_DEPTH];

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  logic [AW:0] wr_ptr_q, wr_ptr_d;
  logic [AW:0] rd_ptr_q, rd_ptr_d;
  logic        do_wr;
  logic        do_rd;

  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign rd_data = mem[rd_ptr_q[AW-1:0]];

  always_comb begin
    do_wr    = wr_en & ~full;
    do_rd    = rd_en & ~empty;
    wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, do_wr};
    rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, do_rd};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_wr) begin
      mem[wr_ptr_q[AW-1:0]] <= wr_data;
    end
  end

endmodule
`default_nettype wire

// File: rtl/fb_line_fetch.sv
`default_nettype none
// ============================================================================
// Module   : fb_line_fetch
// Purpose  : Fetches one frame-buffer scan line per line_start from the
//            secondary SDRAM host port (pipelined 16-bit reads) into a line
//            FIFO; the pixel side pops words at its own pace.
// Ports    : clk, reset (sync, active-high), enable
//            fb_base, frame_start, line_start  - frame / line control
//            pix_rd, pix_data, pix_valid       - pixel-side pop interface
//            busy                              - FSM not idle
//            sdr_*                             - SDRAM controller host port
//            underrun, overrun, underrun_cnt   - status (optional)
// Config   : FB_FETCH_STATUS_EN adds sticky underrun/overrun flags and a
//            saturating underrun counter; without it empty pops are ignored.
// Revision : 1.0 - initial release
// ============================================================================
module fb_line_fetch
  import fb_fetch_pkg::*;
#(
  parameter int ADR_WIDTH  = SDR_AW,
  parameter int LINE_WORDS = 320,
  parameter int STRIDE     = 320,
  parameter int FIFO_DEPTH = 64
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 enable,
  input  logic [ADR_WIDTH-1:0] fb_base,
  input  logic                 frame_start,
  input  logic                 line_start,
  input  logic                 pix_rd,
  output logic [SDR_DW-1:0]    pix_data,
  output logic                 pix_valid,
  output logic                 busy,
  output logic                 sdr_rd,
  output logic                 sdr_wr,
  output logic [ADR_WIDTH-1:0] sdr_hAddr,
  output logic [SDR_DW-1:0]    sdr_hDIn,
  input  logic                 sdr_earlyOpBegun,
  input  logic                 sdr_rdDone,
  input  logic [SDR_DW-1:0]    sdr_hDOut,
`ifdef FB_FETCH_STATUS_EN
  output logic                 underrun,
  output logic                 overrun,
  output logic [15:0]          underrun_cnt,
`endif
  input  logic                 sdr_rdPending
);

  localparam int IDX_W = 12;
  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  localparam logic [IDX_W-1:0]     LINE_WORDS_L = LINE_WORDS[IDX_W-1:0];
  localparam logic [ADR_WIDTH-1:0] STRIDE_L     = STRIDE[ADR_WIDTH-1:0];
  localparam logic [CNT_W:0]       DEPTH_L      = FIFO_DEPTH[CNT_W:0];

  fb_state_t            state_q, state_d;
  logic [ADR_WIDTH-1:0] line_addr_q, line_addr_d;
  logic [ADR_WIDTH-1:0] base_q, base_d;
  logic [IDX_W-1:0]     word_idx_q, word_idx_d;
  logic [CNT_W-1:0]     outstanding_q, outstanding_d;
  logic [CNT_W-1:0]     fifo_count_q, fifo_count_d;
  logic [SDR_DW-1:0]    pix_data_q, pix_data_d;
  logic                 pix_valid_q, pix_valid_d;

  logic                 accept;
  logic                 push;
  logic                 pop;
  logic                 space_ok;
  logic                 flush_done;
  logic [IDX_W-1:0]     word_idx_inc;
  logic                 fifo_rst;
  logic                 fifo_empty;
  logic [SDR_DW-1:0]    fifo_rdata;
  logic                 unused_fifo_full;
  logic                 unused_rd_pending;

  // Outstanding reads are pacing-tracked locally; the controller's pending
  // flag carries no extra information for this block.
  assign unused_rd_pending = sdr_rdPending;

  assign sdr_wr   = 1'b0;
  assign sdr_hDIn = '0;
  assign busy     = (state_q != ST_IDLE);
  assign pix_data = pix_data_q;
  assign pix_valid = pix_valid_q;

  // Reserve FIFO room for every read in flight so a return never overflows.
  assign space_ok = ({1'b0, fifo_count_q} + {1'b0, outstanding_q}) < DEPTH_L;

  // frame_start gates the request combinationally so it drops the same cycle.
  assign sdr_rd = (state_q == ST_FETCH) && (word_idx_q < LINE_WORDS_L) &&
                  space_ok && !frame_start;

  // Address adder is the port width, so the frame wraps silently.
  assign sdr_hAddr = line_addr_q + ADR_WIDTH'(word_idx_q);

  assign accept     = sdr_rd & sdr_earlyOpBegun;
  assign flush_done = (state_q == ST_FLUSH) && !frame_start &&
                      (outstanding_q == '0);
  // Data returning during (or at the start of) a flush belongs to the
  // abandoned line and is dropped.
  assign push       = sdr_rdDone && (state_q != ST_FLUSH) && !frame_start;
  assign pop        = pix_rd & ~fifo_empty;
  assign fifo_rst   = reset | flush_done;

  always_comb begin
    state_d       = state_q;
    line_addr_d   = line_addr_q;
    base_d        = base_q;
    word_idx_inc  = word_idx_q + {{(IDX_W-1){1'b0}}, accept};
    word_idx_d    = word_idx_inc;
    outstanding_d = outstanding_q + {{(CNT_W-1){1'b0}}, accept}
                                  - {{(CNT_W-1){1'b0}}, sdr_rdDone};
    fifo_count_d  = fifo_count_q + {{(CNT_W-1){1'b0}}, push}
                                 - {{(CNT_W-1){1'b0}}, pop};
    pix_data_d    = pop ? fifo_rdata : pix_data_q;
    pix_valid_d   = pop;

    if (flush_done) begin
      fifo_count_d = '0;
    end

    if (frame_start) begin
      state_d = ST_FLUSH;
      base_d  = fb_base;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (line_start && enable) begin
            state_d    = ST_FETCH;
            word_idx_d = '0;
          end
        end
        ST_FETCH: begin
          if (word_idx_inc == LINE_WORDS_L) begin
            state_d = ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          if (outstanding_q == '0) begin
            line_addr_d = line_addr_q + STRIDE_L;
            state_d     = ST_IDLE;
          end
        end
        ST_FLUSH: begin
          if (outstanding_q == '0) begin
            line_addr_d = base_q;
            state_d     = ST_IDLE;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      line_addr_q   <= '0;
      base_q        <= '0;
      word_idx_q    <= '0;
      outstanding_q <= '0;
      fifo_count_q  <= '0;
      pix_data_q    <= '0;
      pix_valid_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      line_addr_q   <= line_addr_d;
      base_q        <= base_d;
      word_idx_q    <= word_idx_d;
      outstanding_q <= outstanding_d;
      fifo_count_q  <= fifo_count_d;
      pix_data_q    <= pix_data_d;
      pix_valid_q   <= pix_valid_d;
    end
  end

  sync_fifo #(
    .DATA_WIDTH (SDR_DW),
    .RAM_DEPTH  (FIFO_DEPTH)
  ) u_line_fifo (
    .clk     (clk),
    .rst     (fifo_rst),
    .wr_en   (push),
    .wr_data (sdr_hDOut),
    .rd_en   (pop),
    .rd_data (fifo_rdata),
    .empty   (fifo_empty),
    .full    (unused_fifo_full)
  );

`ifdef FB_FETCH_STATUS_EN
  logic        underrun_q, underrun_d;
  logic        overrun_q, overrun_d;
  logic [15:0] underrun_cnt_q, underrun_cnt_d;

  always_comb begin
    underrun_d     = underrun_q;
    overrun_d      = overrun_q;
    underrun_cnt_d = underrun_cnt_q;
    if (frame_start) begin
      underrun_d     = 1'b0;
      overrun_d      = 1'b0;
      underrun_cnt_d = '0;
    end else begin
      if (pix_rd && fifo_empty) begin
        underrun_d = 1'b1;
        if (underrun_cnt_q != UNDERRUN_MAX) begin
          underrun_cnt_d = underrun_cnt_q + 16'd1;
        end
      end
      if (line_start && (state_q != ST_IDLE)) begin
        overrun_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      underrun_q     <= 1'b0;
      overrun_q      <= 1'b0;
      underrun_cnt_q <= '0;
    end else begin
      underrun_q     <= underrun_d;
      overrun_q      <= overrun_d;
      underrun_cnt_q <= underrun_cnt_d;
    end
  end

  assign underrun     = underrun_q;
  assign overrun      = overrun_q;
  assign underrun_cnt = underrun_cnt_q;
`endif

endmodule
`default_nettype wire
